// File: rtl/mem_stall_ctrl.sv
// rtl/mem_stall_ctrl.sv - data-memory stall, load-use bubble and branch flush sequencer (optional: HAZ_PERF_CNT_EN)
module mem_stall_ctrl #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TMO_W          = 8,
    parameter int LU_BUBBLE      = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  ex_rs1,
    input  logic [4:0]  ex_rs2,
    input  logic        ex_use_rs1,
    input  logic        ex_use_rs2,
    input  logic        br_taken_ex,
    input  logic        mem_valid,
    input  logic        mem_is_load,
    input  logic        mem_is_store,
    input  logic [4:0]  rd_mem,
    input  logic        dmem_req_ready,
    input  logic        dmem_rsp_valid,
    output logic        dmem_req_valid,
    output logic        stall_if,
    output logic        stall_ex,
    output logic        stall_mem,
    output logic        bubble_mem,
    output logic        flush_if,
`ifdef HAZ_PERF_CNT_EN
    output logic        dmem_err,
    output logic [31:0] perf_stall_cyc,
    output logic [15:0] perf_lu_bub
`else
    output logic        dmem_err
`endif
);

    typedef enum logic [1:0] {
        ST_RUN = 2'd0,
        ST_REQ = 2'd1,
        ST_RSP = 2'd2,
        ST_LUB = 2'd3
    } state_t;

    localparam bit              TMO_EN   = (TIMEOUT_CYCLES != 0);
    localparam bit              LUB_EN   = (LU_BUBBLE != 0);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             err_q, err_d;

    logic access;
    logic dep;
    logic tmo_hit;
    logic req_c;
    logic stall_c;
    logic stall_mem_c;
    logic bubble_c;

    // Decode the MEM access, the EX dependency on the returning load and the watchdog terminal cycle
    always_comb begin
        access  = mem_valid & (mem_is_load | mem_is_store);
        dep     = (rd_mem != 5'd0) &
                  ((ex_use_rs1 & (ex_rs1 == rd_mem)) | (ex_use_rs2 & (ex_rs2 == rd_mem)));
        tmo_hit = TMO_EN & (tmo_cnt_q == TMO_LAST);
    end

    // Next-state and raw pipeline controls; a handshake on the terminal watchdog cycle beats the abort
    always_comb begin
        state_d     = state_q;
        err_d       = err_q;
        req_c       = 1'b0;
        stall_c     = 1'b0;
        stall_mem_c = 1'b0;
        bubble_c    = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (access) begin
                    req_c = 1'b1;
                    if (!dmem_req_ready) begin
                        state_d     = ST_REQ;
                        stall_c     = 1'b1;
                        stall_mem_c = 1'b1;
                    end else if (mem_is_load) begin
                        state_d     = ST_RSP;
                        stall_c     = 1'b1;
                        stall_mem_c = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                req_c = 1'b1;
                if (dmem_req_ready) begin
                    state_d     = mem_is_load ? ST_RSP : ST_RUN;
                    stall_c     = 1'b1;
                    stall_mem_c = 1'b1;
                end else if (tmo_hit) begin
                    state_d = ST_RUN;
                    err_d   = 1'b1;
                end else begin
                    stall_c     = 1'b1;
                    stall_mem_c = 1'b1;
                end
            end
            ST_RSP: begin
                if (dmem_rsp_valid) begin
                    if (LUB_EN && dep) begin
                        state_d     = ST_LUB;
                        stall_c     = 1'b1;
                        stall_mem_c = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else if (tmo_hit) begin
                    state_d = ST_RUN;
                    err_d   = 1'b1;
                end else begin
                    stall_c     = 1'b1;
                    stall_mem_c = 1'b1;
                end
            end
            ST_LUB: begin
                state_d  = ST_RUN;
                stall_c  = 1'b1;
                bubble_c = 1'b1;
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Watchdog restarts from zero on every entry into REQ or RSP and counts while staying there
    always_comb begin
        tmo_cnt_d = '0;
        if ((state_d == ST_REQ) || (state_d == ST_RSP)) begin
            if (state_d == state_q) begin
                tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
            end
        end
    end

    // State, watchdog counter and sticky error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmo_cnt_q <= tmo_cnt_d;
            err_q     <= err_d;
        end
    end

    // Outputs are forced low while reset is held so an abandoned access shows nothing
    assign dmem_req_valid = rst_n & req_c;
    assign stall_if       = rst_n & stall_c;
    assign stall_ex       = rst_n & stall_c;
    assign stall_mem      = rst_n & stall_mem_c;
    assign bubble_mem     = rst_n & bubble_c;
    assign flush_if       = rst_n & br_taken_ex & ~stall_c;
    assign dmem_err       = err_q;

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] perf_stall_q;
    logic [15:0] perf_lub_q;

    // Saturating counters of front-end stall cycles and load-use bubbles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_q <= '0;
            perf_lub_q   <= '0;
        end else begin
            if (stall_if && (perf_stall_q != '1)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
            if ((state_d == ST_LUB) && (state_q != ST_LUB) && (perf_lub_q != '1)) begin
                perf_lub_q <= perf_lub_q + 16'd1;
            end
        end
    end

    assign perf_stall_cyc = perf_stall_q;
    assign perf_lu_bub    = perf_lub_q;
`endif

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// tb/tb_mem_stall_ctrl.sv - randomized scoreboard bench for mem_stall_ctrl
module tb_mem_stall_ctrl;

    localparam int T = 4;

    logic       clk;
    logic       rst_n;
    logic [4:0] ex_rs1, ex_rs2, rd_mem;
    logic       ex_use_rs1, ex_use_rs2, br_taken_ex;
    logic       mem_valid, mem_is_load, mem_is_store;
    logic       dmem_req_ready, dmem_rsp_valid;
    logic       dmem_req_valid, stall_if, stall_ex, stall_mem, bubble_mem, flush_if, dmem_err;

    // values applied to the EX/MEM register inputs on the next driven cycle
    logic [4:0] n_rs1, n_rs2, n_rd;
    logic       n_u1, n_u2;

    logic [6:0] exp_q[$];
    logic       err_sticky;
    int         checks;
    int         errors;
    int         mon_n;

    mem_stall_ctrl #(
        .TIMEOUT_CYCLES(T),
        .TMO_W(8),
        .LU_BUBBLE(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ex_rs1(ex_rs1),
        .ex_rs2(ex_rs2),
        .ex_use_rs1(ex_use_rs1),
        .ex_use_rs2(ex_use_rs2),
        .br_taken_ex(br_taken_ex),
        .mem_valid(mem_valid),
        .mem_is_load(mem_is_load),
        .mem_is_store(mem_is_store),
        .rd_mem(rd_mem),
        .dmem_req_ready(dmem_req_ready),
        .dmem_rsp_valid(dmem_rsp_valid),
        .dmem_req_valid(dmem_req_valid),
        .stall_if(stall_if),
        .stall_ex(stall_ex),
        .stall_mem(stall_mem),
        .bubble_mem(bubble_mem),
        .flush_if(flush_if),
        .dmem_err(dmem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One pipeline cycle: drive inputs after the edge and queue the outputs the rules demand
    task automatic cyc(input logic rst, input logic mv, input logic ld, input logic st,
                       input logic rdy, input logic rsv, input logic e_req, input logic e_s,
                       input logic e_sm, input logic e_bub, input logic set_err);
        logic       br;
        logic [6:0] e;
        @(posedge clk);
        #1;
        br             = ($urandom_range(0, 2) == 0);
        rst_n          = rst;
        mem_valid      = mv;
        mem_is_load    = ld;
        mem_is_store   = st;
        dmem_req_ready = rdy;
        dmem_rsp_valid = rsv;
        br_taken_ex    = br;
        ex_rs1         = n_rs1;
        ex_rs2         = n_rs2;
        rd_mem         = n_rd;
        ex_use_rs1     = n_u1;
        ex_use_rs2     = n_u2;
        if (!rst) begin
            err_sticky = 1'b0;
            e          = '0;
        end else begin
            e = {e_req, e_s, e_s, e_sm, e_bub, br & ~e_s, err_sticky};
        end
        exp_q.push_back(e);
        if (rst && set_err) err_sticky = 1'b1;
    endtask

    // mode 0: random registers, 1: rd=5 read through rs2, 2: rd=0 read through rs2
    task automatic set_ex(input int mode, output logic dep);
        n_rs1 = 5'($urandom_range(0, 31));
        n_rs2 = 5'($urandom_range(0, 31));
        n_rd  = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        n_u1  = 1'($urandom_range(0, 1));
        n_u2  = 1'($urandom_range(0, 1));
        if (mode == 0) begin
            if ($urandom_range(0, 1) == 1) n_rs1 = n_rd;
            if ($urandom_range(0, 1) == 1) n_rs2 = n_rd;
        end else begin
            n_rd  = (mode == 1) ? 5'd5 : 5'd0;
            n_rs2 = n_rd;
            n_u2  = 1'b1;
        end
        dep = (n_rd != 5'd0) && ((n_u1 && n_rs1 == n_rd) || (n_u2 && n_rs2 == n_rd));
    endtask

    // Memory operation: accepted r cycles after it appears, answered on RSP cycle d
    task automatic do_mem(input bit is_ld, input int r, input int d, input int mode);
        logic dep;
        logic st;
        set_ex(mode, dep);
        st = !is_ld;
        for (int j = 0; ; j++) begin
            if (j == r) begin
                cyc(1, 1, is_ld, st, 1, 1'($urandom_range(0, 1)), 1,
                    (is_ld || j > 0), (is_ld || j > 0), 0, 0);
                break;
            end else if (j == T) begin
                cyc(1, 1, is_ld, st, 0, 1'($urandom_range(0, 1)), 1, 0, 0, 0, 1);
                return;
            end else begin
                cyc(1, 1, is_ld, st, 0, 1'($urandom_range(0, 1)), 1, 1, 1, 0, 0);
            end
        end
        if (!is_ld) return;
        for (int k = 0; ; k++) begin
            if (k == d) begin
                if (dep) begin
                    cyc(1, 1, 1, 0, 1'($urandom_range(0, 1)), 1, 0, 1, 1, 0, 0);
                    cyc(1, 1, 1, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        0, 1, 0, 1, 0);
                end else begin
                    cyc(1, 1, 1, 0, 1'($urandom_range(0, 1)), 1, 0, 0, 0, 0, 0);
                end
                break;
            end else if (k == T - 1) begin
                cyc(1, 1, 1, 0, 1'($urandom_range(0, 1)), 0, 0, 0, 0, 0, 1);
                break;
            end else begin
                cyc(1, 1, 1, 0, 1'($urandom_range(0, 1)), 0, 0, 1, 1, 0, 0);
            end
        end
    endtask

    // Cycle with no memory operation in MEM
    task automatic do_nop();
        logic dep;
        set_ex(0, dep);
        if ($urandom_range(0, 1) == 1) begin
            cyc(1, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0, 0, 0, 0);
        end else begin
            cyc(1, 1, 0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0, 0, 0, 0);
        end
    endtask

    // Monitor: every cycle the DUT outputs are compared against the oldest queued expectation
    initial begin
        logic [6:0] a;
        logic [6:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                a = {dmem_req_valid, stall_if, stall_ex, stall_mem, bubble_mem, flush_if, dmem_err};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL cyc%0d outputs{req,sif,sex,smem,bub,flush,err} got %b want %b",
                             mon_n, a, e);
                end
                mon_n++;
            end
        end
    end

    initial begin
        logic dep;
        checks         = 0;
        errors         = 0;
        mon_n          = 0;
        err_sticky     = 1'b0;
        rst_n          = 1'b0;
        mem_valid      = 1'b0;
        mem_is_load    = 1'b0;
        mem_is_store   = 1'b0;
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b0;
        br_taken_ex    = 1'b0;
        ex_rs1         = '0;
        ex_rs2         = '0;
        rd_mem         = '0;
        ex_use_rs1     = 1'b0;
        ex_use_rs2     = 1'b0;
        n_rs1 = '0; n_rs2 = '0; n_rd = '0; n_u1 = 1'b0; n_u2 = 1'b0;

        cyc(0, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        do_nop();
        do_nop();

        do_mem(0, 0, 0, 0);
        do_mem(1, 2, 3, 0);
        do_mem(1, 0, 1, 1);
        do_mem(1, 1, 0, 2);
        do_mem(0, 3, 0, 0);
        do_mem(0, T + 2, 0, 0);
        do_mem(1, 0, T - 1, 0);
        do_mem(1, 0, T + 1, 0);
        do_mem(1, T, 0, 0);
        do_nop();

        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 3))
                0:       do_nop();
                1:       do_mem(0, $urandom_range(0, 6), 0, 0);
                default: do_mem(1, $urandom_range(0, 6), $urandom_range(0, 5), 0);
            endcase
        end

        do_mem(1, T + 1, 0, 0);
        set_ex(0, dep);
        cyc(1, 1, 1, 0, 1, 0, 1, 1, 1, 0, 0);
        cyc(1, 1, 1, 0, 0, 0, 0, 1, 1, 0, 0);
        cyc(1, 1, 1, 0, 0, 0, 0, 1, 1, 0, 0);
        cyc(0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        do_nop();
        do_mem(1, 0, T + 2, 0);
        do_mem(1, 0, 0, 1);
        do_nop();

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
